// File: rtl/cheriot_mem_pkg.sv
// rtl/cheriot_mem_pkg.sv - shared types and parameter limits for the data memory responder
//
// Purpose: response-slot struct, legal parameter ranges and an elaboration-time range helper.
// Ports: none (package).

package cheriot_mem_pkg;

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [32:0] rdata;
   } mem_resp_t;

   localparam int unsigned LatencyMin = 1;
   localparam int unsigned LatencyMax = 8;
   localparam int unsigned OutstMin   = 1;
   localparam int unsigned OutstMax   = 8;

   function automatic bit param_in_range(input int unsigned v,
                                         input int unsigned lo,
                                         input int unsigned hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/cheriot_resp_pipe.sv
// rtl/cheriot_resp_pipe.sv - fixed-depth shift register of response slots
//
// Purpose: delays each response slot by exactly Depth cycles; synchronous clear empties it.
// Ports:
//   clk_i  in   clock
//   rst_i  in   synchronous active-high clear of every stage
//   in_i   in   slot entering stage 0 (valid low for an idle cycle)
//   out_o  out  slot held in the last stage

module cheriot_resp_pipe
   import cheriot_mem_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  mem_resp_t in_i,
   output mem_resp_t out_o
);

   mem_resp_t stage_q [Depth];
   mem_resp_t stage_d [Depth];

   always_comb begin
      stage_d[0] = in_i;
      for (int i = 1; i < int'(Depth); i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(Depth); i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign out_o = stage_q[Depth-1];

endmodule

// File: rtl/cheriot_data_mem_resp.sv
// rtl/cheriot_data_mem_resp.sv - memory-side responder for the 33-bit CHERIoT data interface
//
// Purpose: grants requests up to MaxOutstanding in flight, performs the word access at grant
// time into a data array plus resettable per-word tag vector, and returns in-order responses
// Latency cycles after the grant. Out-of-range accesses respond with data_err_o.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   data_req_i            request valid
//   data_is_cap_i         capability access (tag is read / may be set)
//   data_we_i, data_be_i  write strobe and byte enables
//   data_addr_i           byte address, bits [1:0] ignored
//   data_wdata_i          write data, bit 32 is the tag
//   data_gnt_o            combinational grant
//   data_rvalid_o         response valid
//   data_rdata_o          response data (zero for writes and errors)
//   data_err_o            response error, qualified by data_rvalid_o
//   stall_i               withholds grants while high

module cheriot_data_mem_resp
   import cheriot_mem_pkg::*;
#(
   parameter logic [31:0] MemBase        = 32'h2000_0000,
   parameter int unsigned MemWords       = 1024,
   parameter int unsigned Latency        = 2,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        data_req_i,
   input  logic        data_is_cap_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [32:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [32:0] data_rdata_o,
   output logic        data_err_o,
   input  logic        stall_i
);

   localparam int unsigned IW = $clog2(MemWords);
   localparam int unsigned OW = $clog2(MaxOutstanding + 1);
   localparam logic [OW-1:0] MaxOutst  = OW'(MaxOutstanding);
   localparam logic [31:0]   SpanBytes = 32'(4 * MemWords);

   if (!param_in_range(Latency, LatencyMin, LatencyMax)) begin : g_bad_latency
      $error("cheriot_data_mem_resp: Latency out of range");
   end
   if (!param_in_range(MaxOutstanding, OutstMin, OutstMax)) begin : g_bad_outst
      $error("cheriot_data_mem_resp: MaxOutstanding out of range");
   end
   if ((MemWords < 2) || ((MemWords & (MemWords - 1)) != 0)) begin : g_bad_words
      $error("cheriot_data_mem_resp: MemWords must be a power of two >= 2");
   end

   logic [31:0]   mem_q [MemWords];
   logic [MemWords-1:0] tag_q;
   logic [OW-1:0] outst_q, outst_d;

   logic [31:0]   offset;
   logic          in_range;
   logic [IW-1:0] idx;
   logic          accept;
   logic          wr_en;
   mem_resp_t     resp_in;
   mem_resp_t     resp_out;

   // Addresses below MemBase wrap to huge offsets, so one unsigned compare covers both ends.
   assign offset   = data_addr_i - MemBase;
   assign in_range = offset < SpanBytes;
   assign idx      = offset[IW+1:2];

   // Uses the pre-decrement count so the grant never depends on this cycle's response.
   assign data_gnt_o = data_req_i & ~stall_i & (outst_q < MaxOutst);
   assign accept     = data_gnt_o;
   assign wr_en      = accept & data_we_i & in_range;

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int k = 0; k < 4; k++) begin
            if (data_be_i[k]) begin
               mem_q[idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
            end
         end
      end
   end

   // A capability write keeps its tag only when the whole word is written.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tag_q <= '0;
      end else if (wr_en) begin
         if (data_is_cap_i) begin
            tag_q[idx] <= data_wdata_i[32] & (data_be_i == 4'hF);
         end else if (|data_be_i) begin
            tag_q[idx] <= 1'b0;
         end
      end
   end

   always_comb begin
      resp_in       = '0;
      resp_in.valid = accept;
      resp_in.err   = accept & ~in_range;
      if (accept && in_range && !data_we_i) begin
         resp_in.rdata = {tag_q[idx] & data_is_cap_i, mem_q[idx]};
      end
   end

   cheriot_resp_pipe #(
      .Depth (Latency)
   ) u_resp_pipe (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .in_i  (resp_in),
      .out_o (resp_out)
   );

   assign data_rvalid_o = resp_out.valid;
   assign data_err_o    = resp_out.err;
   assign data_rdata_o  = resp_out.rdata;

   always_comb begin
      outst_d = outst_q;
      unique case ({accept, data_rvalid_o})
         2'b10:   outst_d = outst_q + 1'b1;
         2'b01:   outst_d = outst_q - 1'b1;
         default: outst_d = outst_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         outst_q <= '0;
      end else begin
         outst_q <= outst_d;
      end
   end

endmodule
